// File: rtl/abr_sum_tree_sched.sv
// Multi-beat accumulation controller around a combinational sum tree.
// Each accepted beat is reduced by the tree into a registered partial,
// which is then folded into a running accumulator. A job of N beats is
// started, fed, drained and handed off with valid/ready handshakes.

// Combinational masked sum tree: lanes whose valid bit is low contribute
// zero, the rest are added pairwise in a balanced binary tree.
module abr_prim_sum_tree #(
  parameter int NumSrc = 32,
  parameter int Width  = 8
) (
  input  logic [NumSrc*Width-1:0] values_i,
  input  logic [NumSrc-1:0]       valid_i,
  output logic [Width-1:0]        sum_o,
  output logic                    any_valid_o
);

  localparam int Levels    = $clog2(NumSrc);
  localparam int NumLeaves = 1 << Levels;
  localparam int NumNodes  = 2 * NumLeaves - 1;

  // Node 0 is the root; leaves start at NumLeaves-1. Unused leaves stay 0.
  logic [Width-1:0] node [NumNodes];

  // Build leaves from masked lanes, then reduce each level pairwise.
  always_comb begin
    for (int n = 0; n < NumNodes; n++) begin
      node[n] = '0;
    end
    for (int l = 0; l < NumSrc; l++) begin
      if (valid_i[l]) begin
        node[NumLeaves - 1 + l] = values_i[l*Width +: Width];
      end
    end
    for (int n = NumLeaves - 2; n >= 0; n--) begin
      node[n] = node[2*n + 1] + node[2*n + 2];
    end
  end

  assign sum_o       = node[0];
  assign any_valid_o = |valid_i;

endmodule

module abr_sum_tree_sched #(
  parameter int NumSrc   = 32,
  parameter int Width    = 8,
  parameter int MaxBeats = 16,
  parameter int BeatW    = $clog2(MaxBeats + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_b,
  input  logic                    start_i,
  input  logic [BeatW-1:0]        num_beats_i,
  output logic                    busy_o,
  output logic                    err_o,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [NumSrc*Width-1:0] in_values_i,
  input  logic [NumSrc-1:0]       in_mask_i,
  output logic                    sum_valid_o,
  input  logic                    sum_ready_i,
  output logic [Width-1:0]        sum_o,
  output logic                    sum_any_o,
  output logic [BeatW-1:0]        beat_cnt_o
);

  localparam logic [BeatW-1:0] MaxBeatsW = BeatW'(MaxBeats);
  localparam logic [BeatW-1:0] OneBeat   = BeatW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [BeatW-1:0] num_beats_q, num_beats_d;
  logic [BeatW-1:0] beat_cnt_q, beat_cnt_d;
  logic [Width-1:0] acc_q, acc_d;
  logic             any_q, any_d;
  logic [Width-1:0] part_q, part_d;
  logic             part_any_q, part_any_d;
  logic             part_vld_q, part_vld_d;
  logic             err_q, err_d;

  logic [Width-1:0] tree_sum;
  logic             tree_any;
  logic             in_ready;
  logic             beat_hs;

  abr_prim_sum_tree #(
    .NumSrc (NumSrc),
    .Width  (Width)
  ) u_tree (
    .values_i    (in_values_i),
    .valid_i     (in_mask_i),
    .sum_o       (tree_sum),
    .any_valid_o (tree_any)
  );

  // Next-state, datapath update and handshake decode for the job sequencer.
  always_comb begin
    state_d     = state_q;
    num_beats_d = num_beats_q;
    beat_cnt_d  = beat_cnt_q;
    acc_d       = acc_q;
    any_d       = any_q;
    part_d      = part_q;
    part_any_d  = part_any_q;
    part_vld_d  = part_vld_q;
    err_d       = 1'b0;

    in_ready = (state_q == ACCUM) && (beat_cnt_q < num_beats_q);
    beat_hs  = in_valid_i && in_ready;

    // A start request outside IDLE never disturbs the running job.
    if (state_q != IDLE && start_i) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (num_beats_i > MaxBeatsW) begin
            err_d = 1'b1;
          end else begin
            num_beats_d = num_beats_i;
            beat_cnt_d  = '0;
            acc_d       = '0;
            any_d       = 1'b0;
            part_vld_d  = 1'b0;
            state_d     = (num_beats_i == '0) ? OUT : ACCUM;
          end
        end
      end

      ACCUM: begin
        if (part_vld_q) begin
          acc_d = acc_q + part_q;
          any_d = any_q | part_any_q;
        end
        part_vld_d = beat_hs;
        if (beat_hs) begin
          part_d     = tree_sum;
          part_any_d = tree_any;
          beat_cnt_d = beat_cnt_q + OneBeat;
          if (beat_cnt_q + OneBeat == num_beats_q) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (part_vld_q) begin
          acc_d = acc_q + part_q;
          any_d = any_q | part_any_q;
        end
        part_vld_d = 1'b0;
        state_d    = OUT;
      end

      OUT: begin
        if (sum_ready_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_b) begin
      state_q     <= IDLE;
      num_beats_q <= '0;
      beat_cnt_q  <= '0;
      acc_q       <= '0;
      any_q       <= 1'b0;
      part_q      <= '0;
      part_any_q  <= 1'b0;
      part_vld_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_beats_q <= num_beats_d;
      beat_cnt_q  <= beat_cnt_d;
      acc_q       <= acc_d;
      any_q       <= any_d;
      part_q      <= part_d;
      part_any_q  <= part_any_d;
      part_vld_q  <= part_vld_d;
      err_q       <= err_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign err_o       = err_q;
  assign in_ready_o  = in_ready;
  assign sum_valid_o = (state_q == OUT);
  assign sum_o       = acc_q;
  assign sum_any_o   = any_q;
  assign beat_cnt_o  = beat_cnt_q;

endmodule

// File: tb/tb_abr_sum_tree_sched.sv
// Self-checking bench for abr_sum_tree_sched: a table of uniform jobs with
// hand-derived results, a few hand-written corner sequences, and random
// jobs checked against a job-level arithmetic model.
module tb_abr_sum_tree_sched;

  localparam int NumSrc   = 32;
  localparam int Width    = 8;
  localparam int MaxBeats = 16;
  localparam int BeatW    = $clog2(MaxBeats + 1);

  logic                    clk_i = 1'b0;
  logic                    rst_b;
  logic                    start_i;
  logic [BeatW-1:0]        num_beats_i;
  logic                    busy_o;
  logic                    err_o;
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [NumSrc*Width-1:0] in_values_i;
  logic [NumSrc-1:0]       in_mask_i;
  logic                    sum_valid_o;
  logic                    sum_ready_i;
  logic [Width-1:0]        sum_o;
  logic                    sum_any_o;
  logic [BeatW-1:0]        beat_cnt_o;

  int checks   = 0;
  int failures = 0;

  logic [Width-1:0]  job_vals [MaxBeats][NumSrc];
  logic [NumSrc-1:0] job_mask [MaxBeats];

  typedef struct {
    int                n;
    logic [Width-1:0]  val;
    logic [NumSrc-1:0] mask;
    int                gap;
    int                hold;
    logic [Width-1:0]  exp_sum;
    logic              exp_any;
  } vec_t;

  vec_t vecs [8];

  abr_sum_tree_sched #(
    .NumSrc   (NumSrc),
    .Width    (Width),
    .MaxBeats (MaxBeats)
  ) dut (
    .clk_i       (clk_i),
    .rst_b       (rst_b),
    .start_i     (start_i),
    .num_beats_i (num_beats_i),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_values_i (in_values_i),
    .in_mask_i   (in_mask_i),
    .sum_valid_o (sum_valid_o),
    .sum_ready_i (sum_ready_i),
    .sum_o       (sum_o),
    .sum_any_o   (sum_any_o),
    .beat_cnt_o  (beat_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Job-level reference: plain sum of all unmasked lanes over all beats.
  function automatic void modelJob(input int n, output logic [Width-1:0] s, output logic any);
    int total = 0;
    any = 1'b0;
    for (int b = 0; b < n; b++) begin
      for (int l = 0; l < NumSrc; l++) begin
        if (job_mask[b][l]) total += int'(job_vals[b][l]);
      end
      if (job_mask[b] != '0) any = 1'b1;
    end
    s = Width'(total % (1 << Width));
  endfunction

  task automatic fillUniform(input int n, input logic [Width-1:0] val, input logic [NumSrc-1:0] mask);
    for (int b = 0; b < n; b++) begin
      for (int l = 0; l < NumSrc; l++) job_vals[b][l] = val;
      job_mask[b] = mask;
    end
  endtask

  task automatic randomLanes();
    for (int l = 0; l < NumSrc; l++) in_values_i[l*Width +: Width] = Width'($urandom);
    in_mask_i = NumSrc'($urandom);
  endtask

  task automatic driveBeat(input int b);
    for (int l = 0; l < NumSrc; l++) in_values_i[l*Width +: Width] = job_vals[b][l];
    in_mask_i = job_mask[b];
  endtask

  // Runs one complete job from IDLE through result acceptance.
  task automatic applyStimulus(input string tag, input int n, input int gap, input int hold,
                               input logic [Width-1:0] exp_sum, input logic exp_any);
    int waitc;
    // stray beat while idle must be ignored
    in_valid_i = 1'b1;
    randomLanes();
    @(negedge clk_i);
    checkOutput({tag, " idle_busy"}, 32'(busy_o), 32'd0);
    in_valid_i  = 1'b0;
    start_i     = 1'b1;
    num_beats_i = BeatW'(n);
    @(negedge clk_i);
    start_i = 1'b0;
    checkOutput({tag, " start_busy"}, 32'(busy_o), 32'd1);
    checkOutput({tag, " start_err"}, 32'(err_o), 32'd0);
    checkOutput({tag, " start_cnt"}, 32'(beat_cnt_o), 32'd0);
    for (int b = 0; b < n; b++) begin
      repeat (gap) begin
        in_valid_i  = 1'b0;
        start_i     = 1'($urandom);
        num_beats_i = BeatW'($urandom);
        randomLanes();
        @(negedge clk_i);
      end
      start_i    = 1'b0;
      in_valid_i = 1'b1;
      driveBeat(b);
      checkOutput({tag, " beat_ready"}, 32'(in_ready_o), 32'd1);
      @(negedge clk_i);
      in_valid_i = 1'b0;
    end
    if (n > 0) begin
      checkOutput({tag, " drain_ready"}, 32'(in_ready_o), 32'd0);
      checkOutput({tag, " drain_valid"}, 32'(sum_valid_o), 32'd0);
    end
    waitc = 1;
    while (!sum_valid_o && waitc < 20) begin
      @(negedge clk_i);
      waitc++;
    end
    checkOutput({tag, " latency"}, 32'(waitc), (n == 0) ? 32'd1 : 32'd2);
    checkOutput({tag, " sum"}, 32'(sum_o), 32'(exp_sum));
    checkOutput({tag, " any"}, 32'(sum_any_o), 32'(exp_any));
    checkOutput({tag, " beat_cnt"}, 32'(beat_cnt_o), 32'(n));
    for (int i = 0; i < hold; i++) begin
      sum_ready_i = 1'b0;
      start_i     = (i % 2 == 0);
      num_beats_i = BeatW'(1);
      in_valid_i  = 1'b1;
      randomLanes();
      @(negedge clk_i);
      checkOutput({tag, " hold_valid"}, 32'(sum_valid_o), 32'd1);
      checkOutput({tag, " hold_sum"}, 32'(sum_o), 32'(exp_sum));
      checkOutput({tag, " hold_err"}, 32'(err_o), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    start_i     = 1'b0;
    in_valid_i  = 1'b0;
    sum_ready_i = 1'b1;
    @(negedge clk_i);
    sum_ready_i = 1'b0;
    checkOutput({tag, " done_valid"}, 32'(sum_valid_o), 32'd0);
    checkOutput({tag, " done_busy"}, 32'(busy_o), 32'd0);
    checkOutput({tag, " done_err"}, 32'(err_o), 32'd0);
    checkOutput({tag, " done_cnt"}, 32'(beat_cnt_o), 32'(n));
  endtask

  initial begin
    logic [Width-1:0] es;
    logic             ea;
    int               n;

    vecs[0] = '{n:1,  val:8'h01, mask:32'hFFFF_FFFF, gap:0, hold:5, exp_sum:8'd32,  exp_any:1'b1};
    vecs[1] = '{n:2,  val:8'hFF, mask:32'h0000_0000, gap:0, hold:1, exp_sum:8'h00,  exp_any:1'b0};
    vecs[2] = '{n:2,  val:8'hFF, mask:32'hFFFF_FFFF, gap:1, hold:0, exp_sum:8'hC0,  exp_any:1'b1};
    vecs[3] = '{n:4,  val:8'h03, mask:32'h0000_000F, gap:1, hold:2, exp_sum:8'd48,  exp_any:1'b1};
    vecs[4] = '{n:16, val:8'h01, mask:32'hFFFF_FFFF, gap:0, hold:1, exp_sum:8'h00,  exp_any:1'b1};
    vecs[5] = '{n:5,  val:8'h02, mask:32'h8000_0001, gap:2, hold:0, exp_sum:8'd20,  exp_any:1'b1};
    vecs[6] = '{n:3,  val:8'h80, mask:32'h0000_0003, gap:0, hold:3, exp_sum:8'h00,  exp_any:1'b1};
    vecs[7] = '{n:0,  val:8'hAA, mask:32'hFFFF_FFFF, gap:0, hold:2, exp_sum:8'h00,  exp_any:1'b0};

    rst_b       = 1'b1;
    start_i     = 1'b0;
    num_beats_i = '0;
    in_valid_i  = 1'b0;
    in_values_i = '0;
    in_mask_i   = '0;
    sum_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("reset busy", 32'(busy_o), 32'd0);
    checkOutput("reset err", 32'(err_o), 32'd0);
    checkOutput("reset ready", 32'(in_ready_o), 32'd0);
    checkOutput("reset valid", 32'(sum_valid_o), 32'd0);
    checkOutput("reset sum", 32'(sum_o), 32'd0);
    checkOutput("reset any", 32'(sum_any_o), 32'd0);
    checkOutput("reset cnt", 32'(beat_cnt_o), 32'd0);
    rst_b = 1'b0;
    @(negedge clk_i);

    for (int v = 0; v < 8; v++) begin
      fillUniform(vecs[v].n, vecs[v].val, vecs[v].mask);
      applyStimulus($sformatf("vec%0d", v), vecs[v].n, vecs[v].gap, vecs[v].hold,
                    vecs[v].exp_sum, vecs[v].exp_any);
    end

    // lane 0 only, values 5, 7, 9 with two idle cycles between beats
    for (int b = 0; b < 3; b++) begin
      for (int l = 0; l < NumSrc; l++) job_vals[b][l] = Width'($urandom);
      job_vals[b][0] = Width'(5 + 2 * b);
      job_mask[b]    = 32'h0000_0001;
    end
    applyStimulus("lane0", 3, 2, 2, 8'd21, 1'b1);

    // oversized job request is rejected with an error pulse
    start_i     = 1'b1;
    num_beats_i = BeatW'(MaxBeats + 1);
    @(negedge clk_i);
    start_i = 1'b0;
    checkOutput("oversize err", 32'(err_o), 32'd1);
    checkOutput("oversize busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    checkOutput("oversize err_clear", 32'(err_o), 32'd0);
    checkOutput("oversize busy_after", 32'(busy_o), 32'd0);

    // reset in the middle of a 4-beat job
    fillUniform(4, 8'h11, 32'hFFFF_FFFF);
    start_i     = 1'b1;
    num_beats_i = BeatW'(4);
    @(negedge clk_i);
    start_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid_i = 1'b1;
      driveBeat(b);
      @(negedge clk_i);
    end
    in_valid_i = 1'b0;
    checkOutput("abort cnt_before", 32'(beat_cnt_o), 32'd2);
    rst_b = 1'b1;
    @(negedge clk_i);
    checkOutput("abort busy", 32'(busy_o), 32'd0);
    checkOutput("abort err", 32'(err_o), 32'd0);
    checkOutput("abort ready", 32'(in_ready_o), 32'd0);
    checkOutput("abort valid", 32'(sum_valid_o), 32'd0);
    checkOutput("abort sum", 32'(sum_o), 32'd0);
    checkOutput("abort any", 32'(sum_any_o), 32'd0);
    checkOutput("abort cnt", 32'(beat_cnt_o), 32'd0);
    rst_b = 1'b0;
    @(negedge clk_i);
    fillUniform(1, 8'h03, 32'h0000_0007);
    applyStimulus("post_reset", 1, 0, 1, 8'd9, 1'b1);

    // random jobs checked against the arithmetic model
    for (int j = 0; j < 25; j++) begin
      n = $urandom_range(1, MaxBeats);
      for (int b = 0; b < n; b++) begin
        for (int l = 0; l < NumSrc; l++) job_vals[b][l] = Width'($urandom);
        case ($urandom_range(0, 3))
          0:       job_mask[b] = '0;
          1:       job_mask[b] = '1;
          default: job_mask[b] = NumSrc'($urandom);
        endcase
      end
      modelJob(n, es, ea);
      applyStimulus($sformatf("rand%0d", j), n, $urandom_range(0, 2), $urandom_range(0, 3), es, ea);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
